// File: rtl/can_rx_fifo.sv
// Receive frame buffer behind the CAN controller: ID/EXT acceptance filter,
// DEPTH-entry frame FIFO, 4-register bus window and level/overflow interrupt.
module can_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [28:0] in_id,
    input  logic        in_ext,
    input  logic        in_rtr,
    input  logic [3:0]  in_dlc,
    input  logic [63:0] in_data,
    input  logic        cs,
    input  logic [1:0]  rs,
    input  logic        wr,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);

    // Frame storage; deliberately not reset, only the pointers are.
    logic [28:0] id_mem   [DEPTH];
    logic        ext_mem  [DEPTH];
    logic        rtr_mem  [DEPTH];
    logic [3:0]  dlc_mem  [DEPTH];
    logic [63:0] data_mem [DEPTH];

    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drops_q, drops_d;
    logic [1:0]    irqen_q;
    logic          irq_q;
    logic          match_ext_q, mask_ext_q;
    logic [28:0]   match_id_q, mask_id_q;

    logic wr_en, pop_req, clr, accepted, empty, full, pop, push, drop;
    logic unused_d29;

    assign unused_d29 = d[29];
    assign wr_en      = cs & wr;
    assign pop_req    = wr_en && (rs == 2'd1) && d[8];
    assign clr        = wr_en && (rs == 2'd1) && d[9];
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign accepted   = (((in_id ^ match_id_q) & mask_id_q) == 29'd0)
                        && (!mask_ext_q || (in_ext == match_ext_q));
    assign pop        = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the frame.
    assign push       = ~reset & in_valid & accepted & (~full | pop);
    assign drop       = in_valid & accepted & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != 8'hFF)
                drops_d = drops_q + 8'd1;
        end
        if (clr) begin
            ovf_d   = 1'b0;
            drops_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drops_q     <= 8'd0;
            irqen_q     <= 2'b00;
            irq_q       <= 1'b0;
            match_ext_q <= 1'b0;
            match_id_q  <= 29'd0;
            mask_ext_q  <= 1'b0;
            mask_id_q   <= 29'd0;
        end else begin
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
            irq_q   <= (irqen_q[0] & ~empty) | (irqen_q[1] & ovf_q);
            if (wr_en) begin
                case (rs)
                    2'd0: begin
                        match_ext_q <= d[31];
                        match_id_q  <= d[28:0];
                    end
                    2'd1: irqen_q <= d[31:30];
                    2'd2: begin
                        mask_ext_q <= d[31];
                        mask_id_q  <= d[28:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wptr_q]   <= in_id;
            ext_mem[wptr_q]  <= in_ext;
            rtr_mem[wptr_q]  <= in_rtr;
            dlc_mem[wptr_q]  <= in_dlc;
            data_mem[wptr_q] <= in_data;
        end
    end

    assign irq = irq_q;

    // Head fields read as zero while the FIFO is empty.
    always_comb begin
        q = 32'd0;
        if (cs && !wr) begin
            case (rs)
                2'd0: if (!empty)
                    q = {ext_mem[rptr_q], rtr_mem[rptr_q], 1'b0, id_mem[rptr_q]};
                2'd1:
                    q = {irqen_q, 6'b0, {{(8-CW){1'b0}}, count_q}, drops_q,
                         1'b0, ovf_q, full, empty, (empty ? 4'd0 : dlc_mem[rptr_q])};
                2'd2: if (!empty)
                    q = data_mem[rptr_q][31:0];
                default: if (!empty)
                    q = data_mem[rptr_q][63:32];
            endcase
        end
    end
endmodule

// File: tb/tb_can_rx_fifo.sv
// Directed bench for can_rx_fifo (DEPTH=4): filter, FIFO order, overflow,
// drop saturation, register window and interrupt timing.
module tb_can_rx_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [28:0] in_id;
    logic        in_ext;
    logic        in_rtr;
    logic [3:0]  in_dlc;
    logic [63:0] in_data;
    logic        cs;
    logic [1:0]  rs;
    logic        wr;
    logic [31:0] d;
    logic [31:0] q;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    can_rx_fifo #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_id(in_id),
        .in_ext(in_ext), .in_rtr(in_rtr), .in_dlc(in_dlc), .in_data(in_data),
        .cs(cs), .rs(rs), .wr(wr), .d(d), .q(q), .irq(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [28:0] id, input logic e,
                        input logic r, input logic [3:0] dl, input logic [63:0] dt,
                        input logic we, input logic [1:0] rsel, input logic [31:0] wd);
        in_valid = v; in_id = id; in_ext = e; in_rtr = r; in_dlc = dl; in_data = dt;
        cs = we; wr = we; rs = rsel; d = wd;
        tick();
        in_valid = 1'b0; cs = 1'b0; wr = 1'b0; d = 32'd0;
    endtask

    task automatic push(input logic [28:0] id, input logic e, input logic [3:0] dl);
        step(1'b1, id, e, 1'b0, dl, 64'hDEAD_BEEF_0000_0000, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wreg(input logic [1:0] rsel, input logic [31:0] wd);
        step(1'b0, 29'd0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, rsel, wd);
    endtask

    task automatic rreg(input logic [1:0] rsel, output logic [31:0] v);
        cs = 1'b1; wr = 1'b0; rs = rsel;
        #1;
        v = q;
        cs = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] rsel, input logic [31:0] exp);
        logic [31:0] v;
        rreg(rsel, v);
        chk(tag, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; in_valid = 1'b0; in_id = '0; in_ext = 1'b0; in_rtr = 1'b0;
        in_dlc = '0; in_data = '0; cs = 1'b0; rs = 2'd0; wr = 1'b0; d = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk_reg("rst_stat", 2'd1, 32'h0000_0010);
        chk_reg("rst_head", 2'd0, 32'h0000_0000);

        // Single frame through the window
        step(1'b1, 29'h123, 1'b0, 1'b0, 4'd8, 64'h0807_0605_0403_0201, 1'b0, 2'd0, 32'd0);
        chk_reg("one_stat", 2'd1, 32'h0001_0008);
        chk_reg("one_id", 2'd0, 32'h0000_0123);
        chk_reg("one_lo", 2'd2, 32'h0403_0201);
        chk_reg("one_hi", 2'd3, 32'h0807_0605);
        cs = 1'b0; wr = 1'b0; rs = 2'd3; #1;
        chk("q_nocs", q, 32'd0);
        cs = 1'b1; wr = 1'b1; #1;
        chk("q_write", q, 32'd0);
        cs = 1'b0; wr = 1'b0;
        wreg(2'd1, 32'h0000_0100);
        chk_reg("one_pop", 2'd1, 32'h0000_0010);

        // Extended remote frame flags
        step(1'b1, 29'h1ABC_DEF, 1'b1, 1'b1, 4'd3, 64'd0, 1'b0, 2'd0, 32'd0);
        chk_reg("ext_id", 2'd0, 32'hC1AB_CDEF);
        wreg(2'd1, 32'h0000_0100);

        // Filter: in_valid coinciding with mask write uses the old mask
        wreg(2'd0, 32'h0000_0100);
        step(1'b1, 29'h0FF, 1'b0, 1'b0, 4'd1, 64'd0, 1'b1, 2'd2, 32'h0000_0700);
        chk_reg("flt_old", 2'd0, 32'h0000_00FF);
        wreg(2'd1, 32'h0000_0100);
        push(29'h1FF, 1'b0, 4'd2);
        push(29'h0FF, 1'b0, 4'd3);
        chk_reg("flt_stat", 2'd1, 32'h0001_0002);
        chk_reg("flt_id", 2'd0, 32'h0000_01FF);
        wreg(2'd1, 32'h0000_0100);
        // EXT-only filter: match_ext=0 already, mask_ext=1
        wreg(2'd2, 32'h8000_0000);
        push(29'h001, 1'b1, 4'd0);
        push(29'h002, 1'b0, 4'd0);
        chk_reg("fext_stat", 2'd1, 32'h0001_0000);
        chk_reg("fext_id", 2'd0, 32'h0000_0002);
        wreg(2'd1, 32'h0000_0100);
        wreg(2'd2, 32'h0000_0000);

        // Overflow: DEPTH+2 frames, no pop
        for (int i = 0; i < 6; i++) push(29'h10 + 29'(i), 1'b0, 4'(i));
        chk_reg("ovf_stat", 2'd1, 32'h0004_0260);
        chk_reg("ovf_head", 2'd0, 32'h0000_0010);
        wreg(2'd1, 32'h0000_0200);
        chk_reg("ovf_clr", 2'd1, 32'h0004_0020);

        // Push and pop together while full
        step(1'b1, 29'h20, 1'b0, 1'b0, 4'd7, 64'd0, 1'b1, 2'd1, 32'h0000_0100);
        chk_reg("pp_stat", 2'd1, 32'h0004_0021);
        wreg(2'd1, 32'h0000_0100);
        chk_reg("pp_h12", 2'd0, 32'h0000_0012);
        wreg(2'd1, 32'h0000_0100);
        chk_reg("pp_h13", 2'd0, 32'h0000_0013);
        wreg(2'd1, 32'h0000_0100);
        chk_reg("pp_h20", 2'd0, 32'h0000_0020);
        wreg(2'd1, 32'h0000_0100);
        chk_reg("pp_empty", 2'd1, 32'h0000_0010);

        // Wrap-around: 3*DEPTH push/pop pairs
        for (int i = 0; i < 12; i++) begin
            push(29'h300 + 29'(i), 1'b0, 4'd0);
            chk_reg("wrap_id", 2'd0, 32'h300 + 32'(i));
            rreg(2'd1, v);
            chk("wrap_cnt", {24'd0, v[23:16]}, 32'd1);
            wreg(2'd1, 32'h0000_0100);
        end

        // Drop counter saturates at 255; clear beats a same-cycle drop
        for (int i = 0; i < 260; i++) push(29'h400 + 29'(i), 1'b0, 4'(i));
        chk_reg("sat_stat", 2'd1, 32'h0004_FF60);
        step(1'b1, 29'h4FF, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 2'd1, 32'h0000_0200);
        chk_reg("clr_win", 2'd1, 32'h0004_0020);
        chk_reg("sat_head", 2'd0, 32'h0000_0400);
        for (int i = 0; i < 4; i++) wreg(2'd1, 32'h0000_0100);
        chk_reg("sat_flush", 2'd1, 32'h0000_0010);

        // Level interrupt
        wreg(2'd1, 32'h4000_0000);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        push(29'h50, 1'b0, 4'd0);
        chk("irq_lag", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_rise", {31'd0, irq}, 32'd1);
        push(29'h51, 1'b0, 4'd0);
        wreg(2'd1, 32'h4000_0100);
        wreg(2'd1, 32'h4000_0100);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_fall", {31'd0, irq}, 32'd0);
        wreg(2'd1, 32'h4000_0100);
        chk_reg("pop_empty", 2'd1, 32'h4000_0010);

        // Overflow interrupt
        wreg(2'd1, 32'h8000_0000);
        for (int i = 0; i < 5; i++) push(29'h60 + 29'(i), 1'b0, 4'd0);
        chk("oirq_lag", {31'd0, irq}, 32'd0);
        tick();
        chk("oirq_rise", {31'd0, irq}, 32'd1);
        wreg(2'd1, 32'h8000_0200);
        tick();
        chk("oirq_fall", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) wreg(2'd1, 32'h0000_0100);

        // Mid-operation reset flushes entries, filter and irqen
        wreg(2'd1, 32'h4000_0000);
        push(29'h70, 1'b0, 4'd0);
        push(29'h71, 1'b0, 4'd0);
        wreg(2'd0, 32'h0000_0005);
        wreg(2'd2, 32'h1FFF_FFFF);
        tick();
        reset = 1'b1;
        step(1'b1, 29'h72, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 2'd0, 32'd0);
        reset = 1'b0;
        chk_reg("mrst_stat", 2'd1, 32'h0000_0010);
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        push(29'h7, 1'b0, 4'd4);
        chk_reg("mrst_flt", 2'd1, 32'h0001_0004);
        chk_reg("mrst_id", 2'd0, 32'h0000_0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/can_rx_fifo.md
# can_rx_fifo

Receive-side frame buffer placed directly downstream of the CAN controller. It captures each validly received frame (ID, EXT, RTR, DLC, 8 data bytes) on the controller's frame-available pulse. An ID/EXT acceptance filter selects which frames are kept, and kept frames go into a DEPTH-entry FIFO. Software reads and pops the head frame through a 4-register bus window and gets a level/overflow interrupt, so back-to-back frames are not lost while the CPU services earlier ones.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CW, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle pulse; a complete, CRC-good frame is present on in_*.
- in_id  in  29  received identifier; standard IDs in bits [10:0], upper bits 0.
- in_ext  in  1  extended-frame flag.
- in_rtr  in  1  remote-frame flag.
- in_dlc  in  4  data length code.
- in_data  in  64  bytes 0..7; byte0 in [7:0], byte7 in [63:56].
- cs  in  1  register window select (32-bit accesses only).
- rs  in  2  register select.
- wr  in  1  1 = write, 0 = read (qualified by cs).
- d  in  32  write data.
- q  out  32  read data; combinational; 0 when cs=0 or wr=1.
- irq  out  1  interrupt request.

## Operation
Acceptance filter:
- Frame is accepted when ((in_id ^ match_id) & mask_id) == 0.
- If mask_ext=1, in_ext == match_ext is also required.
- After reset, mask is all zero, so every frame is accepted.

Register map, reads (head = oldest entry):
- rs=0: {ext, rtr, 1'b0, id[28:0]} of head.
- rs=1: {irqen[1:0], 6'b0, count (zero-extended to 8), drops[7:0], 1'b0, ovf, full, empty, head dlc[3:0]}.
- rs=2: head bytes 3..0, byte0 in [7:0].
- rs=3: head bytes 7..4.
- When empty, rs=0/2/3 read 0 and the dlc field reads 0.

Register map, writes:
- rs=0: match register; match_ext=d[31], match_id=d[28:0].
- rs=1: irqen<=d[31:30]. d[8]=1 pops the head. d[9]=1 clears ovf and drops.
- rs=2: mask register; mask_ext=d[31], mask_id=d[28:0].
- rs=3: ignored.

FIFO:
- Circular buffer with wptr/rptr (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
- empty = (count==0); full = (count==DEPTH).
- Push: in_valid & accepted & (~full | pop). The entry is written at wptr, then wptr increments.
- Pop: pop strobe & ~empty; rptr increments. A pop when empty is ignored with no side effects.
- Push and pop in the same cycle: both execute and count is unchanged. This holds even when full, so the frame is stored and ovf is not set.
- Accepted frame that arrives while full with no pop: frame discarded, ovf<=1, drops increments and saturates at 255.
- Rejected (filtered) frames change nothing.
- drops increment and d[9] clear in the same cycle: clear wins, result is 0 (same rule for ovf).

Interrupt:
- irq = (irqen[0] & ~empty) | (irqen[1] & ovf). Registered.

## Timing
- Reset (synchronous, evaluated on clk edge) sets:
  - rptr = wptr = count = 0; empty=1, full=0.
  - ovf=0, drops=0, irqen=0, irq=0.
  - match and mask registers = 0.
  - FIFO storage is not reset.
- Reset asserted mid-operation flushes all entries; in_valid in the reset cycle is ignored.
- Push latency: a frame pushed at edge N is readable (empty=0, count updated) from cycle N+1. irq rises at edge N+1.
- Pop: the write cycle with d[8]=1 takes effect at that edge; the next head is readable the following cycle.
- Register writes (match, mask, irqen) take effect at the write edge. A frame whose in_valid coincides with a filter write uses the old filter values.
- q has zero-cycle latency; no wait states.

## Test plan
- Reset, then one in_valid with id=0x123, ext=0, dlc=8, data=0x0807060504030201:
  - next cycle rs=1 reads empty=0, count=1, dlc=8.
  - rs=0 reads 0x00000123; rs=2 reads 0x04030201; rs=3 reads 0x08070605.
  - pop, then rs=1 reads empty=1.
- Filter: match=0x100, mask=0x700. Frames with id 0x1FF and 0x0FF: only 0x1FF is stored (count=1).
- Overflow: DEPTH+2 accepted frames with no pop give full=1, ovf=1, drops=2, and the head is still the first frame. Write rs=1 with d[9]=1 clears ovf=0, drops=0, leaves count=DEPTH.
- Simultaneous push and pop while full: count stays DEPTH, ovf stays 0, and the new frame appears after DEPTH-1 further pops.
- Wrap-around: 3×DEPTH push/pop pairs interleaved give in-order IDs, with count never above 1.
- irqen=2'b01: irq rises one cycle after the first push and falls after the last pop. Pop when empty leaves count=0.
